// File: rtl/inst_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_loader_if
// Brief    : Byte-stream input and instruction-RAM debug write bundle for the
//            program loader. "master" is the upstream side that drives the
//            byte stream; "slave" is the loader that drives the CPU side.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_loader_if #(
  parameter int WORD_COUNT_W = 10
) ();
  logic                    load_req;
  logic                    in_valid;
  logic [7:0]              in_byte;
  logic                    in_ready;
  logic                    debug;
  logic                    inst_ram_write_enable;
  logic [31:0]             inst_ram_write_data;
  logic [31:0]             inst_ram_write_address;
  logic                    cpu_reset;
  logic                    busy;
  logic                    error;
  logic [WORD_COUNT_W:0]   words_loaded;

  modport master (
    output load_req, in_valid, in_byte,
    input  in_ready, debug, inst_ram_write_enable, inst_ram_write_data,
           inst_ram_write_address, cpu_reset, busy, error, words_loaded
  );

  modport slave (
    input  load_req, in_valid, in_byte,
    output in_ready, debug, inst_ram_write_enable, inst_ram_write_data,
           inst_ram_write_address, cpu_reset, busy, error, words_loaded
  );
endinterface
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_loader
// Brief    : Receives a framed byte stream (length, little-endian payload
//            words, XOR checksum), writes the words into instruction RAM via
//            the CPU debug write port and releases the CPU from reset only
//            once the complete frame has been checked.
// Revision : 1.0 - initial release
// ============================================================================
module inst_loader #(
  parameter int          WORD_COUNT_W = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input wire           clk,
  input wire           reset,
  inst_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_CHECK = 3'd4,
    S_RUN   = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  // Largest word count a frame may declare (the counter has one extra bit).
  localparam logic [31:0] MAX_WORDS = 32'd1 << WORD_COUNT_W;

  state_t                state_q;
  logic [15:0]           len_q;
  logic [1:0]            byte_idx_q;
  logic [WORD_COUNT_W:0] word_idx_q;
  logic [7:0]            csum_q;
  logic [23:0]           shift_q;
  logic                  debug_q;
  logic                  we_q;
  logic [31:0]           wdata_q;
  logic [31:0]           waddr_q;
  logic                  cpu_reset_q;
  logic                  busy_q;
  logic                  error_q;
  logic [WORD_COUNT_W:0] words_loaded_q;

  logic                  in_ready;
  logic                  accept;
  logic                  start;
  logic [15:0]           len_d;
  logic [WORD_COUNT_W:0] word_idx_d;
  logic [31:0]           waddr_d;
  logic                  last_word;

  // Ready is a pure state decode so a byte is never taken outside the frame.
  assign in_ready   = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CHECK);
  assign accept     = bus.in_valid && in_ready;
  // A new frame can only be started when no frame is in flight.
  assign start      = bus.load_req &&
                      ((state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_ERROR));
  assign len_d      = {bus.in_byte, len_q[7:0]};
  assign word_idx_d = word_idx_q + 1'b1;
  assign waddr_d    = BASE_ADDR + (32'(word_idx_q) << 2);
  assign last_word  = (32'(word_idx_d) == 32'(len_q));

  // Frame sequencer: state, payload assembly, checksum and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      len_q          <= 16'd0;
      byte_idx_q     <= 2'd0;
      word_idx_q     <= '0;
      csum_q         <= 8'd0;
      shift_q        <= 24'd0;
      debug_q        <= 1'b0;
      we_q           <= 1'b0;
      wdata_q        <= 32'd0;
      waddr_q        <= BASE_ADDR;
      cpu_reset_q    <= 1'b0;
      busy_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (start) begin
        // Hold the CPU and take over the RAM address mux for the whole load.
        state_q     <= S_LEN0;
        debug_q     <= 1'b1;
        cpu_reset_q <= 1'b0;
        busy_q      <= 1'b1;
        error_q     <= 1'b0;
        csum_q      <= 8'd0;
        byte_idx_q  <= 2'd0;
        word_idx_q  <= '0;
        waddr_q     <= BASE_ADDR;
      end else begin
        case (state_q)
          S_LEN0: begin
            if (accept) begin
              len_q[7:0] <= bus.in_byte;
              state_q    <= S_LEN1;
            end
          end
          S_LEN1: begin
            if (accept) begin
              len_q <= len_d;
              if (32'(len_d) > MAX_WORDS) begin
                state_q     <= S_ERROR;
                error_q     <= 1'b1;
                busy_q      <= 1'b0;
                debug_q     <= 1'b1;
                cpu_reset_q <= 1'b0;
              end else if (len_d == 16'd0) begin
                state_q <= S_CHECK;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (accept) begin
              csum_q     <= csum_q ^ bus.in_byte;
              byte_idx_q <= byte_idx_q + 2'd1;
              if (byte_idx_q == 2'd3) begin
                // Fourth byte completes the word: strobe it out next cycle.
                we_q       <= 1'b1;
                wdata_q    <= {bus.in_byte, shift_q};
                waddr_q    <= waddr_d;
                word_idx_q <= word_idx_d;
                if (last_word) begin
                  state_q <= S_CHECK;
                end
              end else begin
                // Earlier bytes enter at the top and drift down, LSB first.
                shift_q <= {bus.in_byte, shift_q[23:8]};
              end
            end
          end
          S_CHECK: begin
            if (accept) begin
              busy_q <= 1'b0;
              if (bus.in_byte == csum_q) begin
                state_q        <= S_RUN;
                debug_q        <= 1'b0;
                cpu_reset_q    <= 1'b1;
                words_loaded_q <= word_idx_q;
              end else begin
                state_q     <= S_ERROR;
                error_q     <= 1'b1;
                debug_q     <= 1'b1;
                cpu_reset_q <= 1'b0;
              end
            end
          end
          default: begin
            // IDLE, RUN and ERROR hold until the next load request.
          end
        endcase
      end
    end
  end

  assign bus.in_ready               = in_ready;
  assign bus.debug                  = debug_q;
  assign bus.inst_ram_write_enable  = we_q;
  assign bus.inst_ram_write_data    = wdata_q;
  assign bus.inst_ram_write_address = waddr_q;
  assign bus.cpu_reset              = cpu_reset_q;
  assign bus.busy                   = busy_q;
  assign bus.error                  = error_q;
  assign bus.words_loaded           = words_loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_loader
// Brief    : Self-checking bench for inst_loader. Expected RAM writes are
//            queued as frame bytes are accepted and compared when strobes
//            appear; end-of-frame status is checked after each frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_loader;
  localparam int          W    = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inst_loader_if #(.WORD_COUNT_W(W)) bus ();

  inst_loader #(.WORD_COUNT_W(W), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] due;
  } wr_t;

  wr_t         sb[$];
  wr_t         mon_e;
  logic [7:0]  frm[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 32'd0;
  logic [31:0] last_addr = 32'hFFFF_FFFF;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (bus.inst_ram_write_enable !== 1'b0) begin
      last_addr = bus.inst_ram_write_address;
      if (sb.size() == 0) begin
        check("strobe_expected", 64'(bus.inst_ram_write_enable), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr",  64'(bus.inst_ram_write_address), 64'(mon_e.addr));
        check("wr_data",  64'(bus.inst_ram_write_data),    64'(mon_e.data));
        check("wr_cycle", 64'(cyc),                        64'(mon_e.due));
        check("wr_debug", 64'(bus.debug),                  64'd1);
      end
    end
  end

  task automatic pulse_load();
    bus.load_req = 1'b1;
    @(posedge clk); #1;
    bus.load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit   done;
    logic rdy;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
    end
    bus.in_valid = 1'b0;
    check("byte_accepted", 64'(done), 64'd1);
  endtask

  // Streams frm; gap_max>0 inserts random idle gaps, lr_at pulses load_req
  // before that byte, rst_at pulses reset instead of sending that byte.
  task automatic send_frame(input int gap_max, input int lr_at, input int rst_at);
    int          n;
    int          p;
    logic [31:0] w;
    n = int'({frm[1], frm[0]});
    w = 32'd0;
    for (int i = 0; i < frm.size(); i++) begin
      if (i == rst_at) begin
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        return;
      end
      if (gap_max > 0) begin
        repeat ($urandom_range(1, gap_max)) @(posedge clk);
        #1;
      end
      if (i == lr_at) pulse_load();
      send_byte(frm[i]);
      p = i - 2;
      if (i >= 2 && p < 4 * n && n <= (1 << W)) begin
        w[8*(p%4) +: 8] = frm[i];
        if (p % 4 == 3) sb.push_back('{BASE + 32'(p / 4) * 32'd4, w, cyc});
      end
    end
  endtask

  task automatic build_frame(input int n, input bit good);
    logic [7:0] ck;
    logic [7:0] b;
    ck = 8'd0;
    frm.delete();
    frm.push_back(8'(n));
    frm.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      ck ^= b;
      frm.push_back(b);
    end
    frm.push_back(good ? ck : ck ^ 8'h01);
  endtask

  task automatic load_t2(input logic [7:0] ck);
    logic [7:0] t2 [11];
    t2 = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
    t2[10] = ck;
    frm.delete();
    foreach (t2[i]) frm.push_back(t2[i]);
  endtask

  task automatic check_run(input string tag, input int n);
    check({tag, "_cpu_reset"},    64'(bus.cpu_reset),    64'd1);
    check({tag, "_debug"},        64'(bus.debug),        64'd0);
    check({tag, "_busy"},         64'(bus.busy),         64'd0);
    check({tag, "_error"},        64'(bus.error),        64'd0);
    check({tag, "_in_ready"},     64'(bus.in_ready),     64'd0);
    check({tag, "_words_loaded"}, 64'(bus.words_loaded), 64'(n));
  endtask

  task automatic check_error(input string tag);
    check({tag, "_error"},     64'(bus.error),     64'd1);
    check({tag, "_cpu_reset"}, 64'(bus.cpu_reset), 64'd0);
    check({tag, "_debug"},     64'(bus.debug),     64'd1);
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load_req = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'd0;
    reset        = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_reset",    64'(bus.cpu_reset),              64'd0);
    check("rst_debug",        64'(bus.debug),                  64'd0);
    check("rst_in_ready",     64'(bus.in_ready),               64'd0);
    check("rst_addr",         64'(bus.inst_ram_write_address), 64'(BASE));
    check("rst_we",           64'(bus.inst_ram_write_enable),  64'd0);
    check("rst_busy",         64'(bus.busy),                   64'd0);
    check("rst_error",        64'(bus.error),                  64'd0);
    check("rst_words_loaded", 64'(bus.words_loaded),           64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Two-word frame, good checksum
    load_t2(8'h2D);
    pulse_load();
    check("len0_busy",     64'(bus.busy),     64'd1);
    check("len0_debug",    64'(bus.debug),    64'd1);
    check("len0_in_ready", 64'(bus.in_ready), 64'd1);
    send_frame(0, -1, -1);
    check_run("t2", 2);

    // Same frame, bad checksum, then restart
    load_t2(8'h2C);
    pulse_load();
    send_frame(0, -1, -1);
    check_error("t3");
    pulse_load();
    check("t3_reload_error", 64'(bus.error),    64'd0);
    check("t3_reload_busy",  64'(bus.busy),     64'd1);
    check("t3_reload_ready", 64'(bus.in_ready), 64'd1);

    // Empty frame straight from the reloaded LEN0
    frm.delete();
    repeat (3) frm.push_back(8'h00);
    send_frame(0, -1, -1);
    check_run("t4", 0);

    // Oversize length, then the largest legal frame
    frm.delete();
    frm.push_back(8'h01);
    frm.push_back(8'h04);
    pulse_load();
    send_frame(0, -1, -1);
    check_error("t5_over");
    check("t5_over_busy", 64'(bus.busy), 64'd0);
    build_frame(1 << W, 1'b1);
    pulse_load();
    send_frame(0, -1, -1);
    check_run("t5_max", 1 << W);
    check("t5_last_addr", 64'(last_addr), 64'h0000_0FFC);

    // Gapped stream with a stray load_req in DATA
    load_t2(8'h2D);
    pulse_load();
    send_frame(5, 5, -1);
    check_run("t6", 2);

    // Reset after six payload bytes
    pulse_load();
    send_frame(5, -1, 8);
    check("t6r_cpu_reset", 64'(bus.cpu_reset),              64'd0);
    check("t6r_debug",     64'(bus.debug),                  64'd0);
    check("t6r_busy",      64'(bus.busy),                   64'd0);
    check("t6r_in_ready",  64'(bus.in_ready),               64'd0);
    check("t6r_addr",      64'(bus.inst_ram_write_address), 64'(BASE));
    check("t6r_words",     64'(bus.words_loaded),           64'd0);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hAA;
    repeat (6) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("t6r_still_idle", 64'(bus.in_ready), 64'd0);
    check("sb_drained",     64'(sb.size()),    64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
